// File: rtl/pht_update_ctrl_if.sv
// Port-B sequencer bundle: committed-branch update handshake plus the BRAM write port.
// Combinational only; no latency, no flow control of its own.
// Backpressure is carried by upd_ready_o; the table side has none.
interface pht_update_ctrl_if #(
    parameter int TABLE_DEPTH_EXP2 = 10,
    parameter int CTR_WIDTH        = 2,
    parameter int PC_WIDTH         = 32
);
    logic                        upd_valid_i;
    logic                        upd_ready_o;
    logic [PC_WIDTH-1:0]         upd_pc_i;
    logic                        upd_taken_i;
    logic [TABLE_DEPTH_EXP2-1:0] tbl_addr_o;
    logic                        tbl_we_o;
    logic [CTR_WIDTH-1:0]        tbl_wdata_o;
    logic [CTR_WIDTH-1:0]        tbl_rdata_i;

    modport master (
        output upd_valid_i, upd_pc_i, upd_taken_i, tbl_rdata_i,
        input  upd_ready_o, tbl_addr_o, tbl_we_o, tbl_wdata_o
    );

    modport slave (
        input  upd_valid_i, upd_pc_i, upd_taken_i, tbl_rdata_i,
        output upd_ready_o, tbl_addr_o, tbl_we_o, tbl_wdata_o
    );
endinterface

// File: rtl/pht_update_ctrl.sv
// PHT port-B owner: optional post-reset init sweep, then FIFO-fed 2-cycle saturating RMW updates.
// Latency: push at edge t -> READ cycle t+1 -> write cycle t+2 (committed at edge t+3); 1 update / 2 cycles.
// Backpressure: upd_ready_o = FIFO not full; pushes accepted in every state. Macro: PHT_INIT_SWEEP_EN.
module pht_update_ctrl #(
    parameter int TABLE_DEPTH_EXP2 = 10,
    parameter int CTR_WIDTH        = 2,
    parameter int PC_WIDTH         = 32,
    parameter int FIFO_DEPTH       = 4,
    parameter int INIT_CTR         = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    pht_update_ctrl_if.slave   bus,
    output logic               init_done_o,
    output logic               busy_o
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [TABLE_DEPTH_EXP2-1:0] idx;
        logic                        taken;
    } ent_t;

    typedef enum logic [1:0] {
`ifdef PHT_INIT_SWEEP_EN
        S_INIT,
`endif
        S_IDLE,
        S_READ,
        S_WRITE
    } state_t;

`ifdef PHT_INIT_SWEEP_EN
    localparam state_t RST_STATE = S_INIT;
`else
    localparam state_t RST_STATE = S_IDLE;
`endif

    function automatic logic [CTR_WIDTH-1:0] sat(input logic [CTR_WIDTH-1:0] c, input logic t);
        if (t) return (c == '1) ? c : c + 1'b1;
        else   return (c == '0) ? c : c - 1'b1;
    endfunction

    state_t                      state_q;
    logic [TABLE_DEPTH_EXP2-1:0] addr_q;
    logic                        we_q;
    ent_t                        mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]            wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic                        push, pop, full;
    ent_t                        head, next_head;
    logic [CTR_WIDTH-1:0]        wdata;
    logic                        unused_pc;

    assign unused_pc = ^{bus.upd_pc_i[PC_WIDTH-1:TABLE_DEPTH_EXP2+2], bus.upd_pc_i[1:0]};

    assign full      = (cnt_q == CNT_W'(FIFO_DEPTH));
    assign push      = bus.upd_valid_i && !full;
    assign pop       = (state_q == S_WRITE);
    assign head      = mem_q[rd_ptr_q];
    assign next_head = mem_q[PTR_W'(rd_ptr_q + 1'b1)];

    always_comb begin
        cnt_d = cnt_q;
        if (push) cnt_d = cnt_d + CNT_W'(1);
        if (pop)  cnt_d = cnt_d - CNT_W'(1);
    end

    // Storage needs no reset: occupancy is governed entirely by the pointers.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= '{idx: bus.upd_pc_i[TABLE_DEPTH_EXP2+1:2], taken: bus.upd_taken_i};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push) wr_ptr_q <= PTR_W'(wr_ptr_q + 1'b1);
            if (pop)  rd_ptr_q <= PTR_W'(rd_ptr_q + 1'b1);
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RST_STATE;
            addr_q  <= '0;
            we_q    <= 1'b0;
        end else begin
            case (state_q)
`ifdef PHT_INIT_SWEEP_EN
                // addr_q doubles as the sweep counter; we_q marks that index 0 was issued.
                S_INIT: begin
                    if (we_q && addr_q == '1) begin
                        state_q <= S_IDLE;
                        we_q    <= 1'b0;
                    end else begin
                        we_q    <= 1'b1;
                        addr_q  <= we_q ? addr_q + 1'b1 : '0;
                    end
                end
`endif
                S_IDLE: begin
                    if (cnt_q != '0) begin
                        state_q <= S_READ;
                        addr_q  <= head.idx;
                    end
                end
                S_READ: begin
                    state_q <= S_WRITE;
                    we_q    <= 1'b1;
                end
                S_WRITE: begin
                    we_q <= 1'b0;
                    // Only entries already queued chain into READ; a same-edge push goes via IDLE.
                    if (cnt_q > CNT_W'(1)) begin
                        state_q <= S_READ;
                        addr_q  <= next_head.idx;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        wdata = '0;
        if (state_q == S_WRITE) wdata = sat(bus.tbl_rdata_i, head.taken);
`ifdef PHT_INIT_SWEEP_EN
        else if (state_q == S_INIT && we_q) wdata = CTR_WIDTH'(INIT_CTR);
`endif
    end

`ifdef PHT_INIT_SWEEP_EN
    assign init_done_o = (state_q != S_INIT);
`else
    logic [CTR_WIDTH-1:0] unused_init_ctr;
    assign unused_init_ctr = CTR_WIDTH'(INIT_CTR);
    assign init_done_o     = 1'b1;
`endif

    assign busy_o          = (state_q != S_IDLE) || (cnt_q != '0);
    assign bus.upd_ready_o = !full;
    assign bus.tbl_addr_o  = addr_q;
    assign bus.tbl_we_o    = we_q;
    assign bus.tbl_wdata_o = wdata;
endmodule

// File: tb/tb_pht_update_ctrl.sv
// Randomized scoreboard bench for pht_update_ctrl with a BRAM model on port B.
module tb_pht_update_ctrl;
    localparam int AW       = 4;
    localparam int CW       = 2;
    localparam int PW       = 32;
    localparam int FD       = 4;
    localparam int INIT_CTR = 1;
    localparam int NENT     = 1 << AW;
    localparam int CMAX     = (1 << CW) - 1;
`ifdef PHT_INIT_SWEEP_EN
    localparam bit SWEEP = 1'b1;
`else
    localparam bit SWEEP = 1'b0;
`endif
    // Cycle index at which the controller first sits in IDLE after reset release.
    localparam int D = SWEEP ? NENT + 1 : 0;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic init_done, busy;

    always #5 clk = ~clk;

    pht_update_ctrl_if #(.TABLE_DEPTH_EXP2(AW), .CTR_WIDTH(CW), .PC_WIDTH(PW)) bus ();

    pht_update_ctrl #(
        .TABLE_DEPTH_EXP2(AW), .CTR_WIDTH(CW), .PC_WIDTH(PW),
        .FIFO_DEPTH(FD), .INIT_CTR(INIT_CTR)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .init_done_o(init_done), .busy_o(busy)
    );

    typedef struct {
        int idx;
        int val;
        int w;
    } exp_t;

    exp_t            sbq[$];
    int              model[NENT];
    logic [CW-1:0]   bram[NENT];
    logic [CW-1:0]   rdata_q;
    int              cyc;
    int              last_w;
    int              vld_pct = 0;
    int              vectors = 0;
    int              errors = 0;
    bit              pend = 1'b0;
    int              pend_idx;
    bit              pend_taken;

    assign bus.tbl_rdata_i = rdata_q;

    // BRAM port B: read-first, 1-cycle read latency; contents scrambled while in reset.
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NENT; i++) bram[i] <= CW'($urandom);
        end else if (bus.tbl_we_o) begin
            bram[bus.tbl_addr_o] <= bus.tbl_wdata_o;
        end
        rdata_q <= bram[bus.tbl_addr_o];
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    function automatic int ref_sat(int c, bit t);
        if (t) return (c >= CMAX) ? CMAX : c + 1;
        return (c <= 0) ? 0 : c - 1;
    endfunction

    function automatic int imax(int a, int b);
        return (a > b) ? a : b;
    endfunction

    task automatic chk(string name, int act, int exp);
        vectors++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cyc=%0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    // Driver: commits the previous cycle's accepted request to the reference model, then drives anew.
    initial begin
        bus.upd_valid_i = 1'b0;
        bus.upd_pc_i    = '0;
        bus.upd_taken_i = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                pend = 1'b0;
                sbq.delete();
                last_w = -100;
                for (int i = 0; i < NENT; i++) model[i] = SWEEP ? INIT_CTR : int'(bram[i]);
                bus.upd_valid_i = 1'b0;
            end else begin
                if (pend) begin
                    exp_t e;
                    model[pend_idx] = ref_sat(model[pend_idx], pend_taken);
                    e.idx = pend_idx;
                    e.val = model[pend_idx];
                    e.w   = imax(imax(cyc + 2, last_w + 2), D + 2);
                    last_w = e.w;
                    sbq.push_back(e);
                    pend = 1'b0;
                end
                begin
                    logic [PW-1:0] pc;
                    int idx;
                    bit v;
                    v   = ($urandom_range(99) < vld_pct);
                    idx = ($urandom_range(1) == 1) ? $urandom_range(2) : $urandom_range(NENT - 1);
                    pc  = $urandom;
                    pc[AW+1:2] = AW'(idx);
                    bus.upd_valid_i = v;
                    bus.upd_pc_i    = pc;
                    bus.upd_taken_i = ($urandom_range(99) < 60);
                    if (v && bus.upd_ready_o) begin
                        pend       = 1'b1;
                        pend_idx   = idx;
                        pend_taken = bus.upd_taken_i;
                    end
                end
            end
        end
    end

    // Monitor: samples on the falling edge, pops the scoreboard when a table write appears.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("rst_we", int'(bus.tbl_we_o), 0);
                chk("rst_addr", int'(bus.tbl_addr_o), 0);
                chk("rst_wdata", int'(bus.tbl_wdata_o), 0);
                chk("rst_init_done", int'(init_done), SWEEP ? 0 : 1);
                chk("rst_ready", int'(bus.upd_ready_o), 1);
                chk("rst_busy", int'(busy), SWEEP ? 1 : 0);
            end else begin
                if (sbq.size() > 0 && cyc > sbq[0].w) begin
                    chk("overdue_write", cyc, sbq[0].w);
                    void'(sbq.pop_front());
                end
                chk("ready", int'(bus.upd_ready_o), (sbq.size() < FD) ? 1 : 0);
                chk("busy", int'(busy), (cyc < D || sbq.size() > 0) ? 1 : 0);
                chk("init_done", int'(init_done), (cyc >= D) ? 1 : 0);
                if (SWEEP && cyc >= 1 && cyc <= NENT) begin
                    chk("sweep_we", int'(bus.tbl_we_o), 1);
                    chk("sweep_addr", int'(bus.tbl_addr_o), cyc - 1);
                    chk("sweep_wdata", int'(bus.tbl_wdata_o), INIT_CTR);
                end else if (sbq.size() > 0 && cyc == sbq[0].w) begin
                    exp_t e;
                    e = sbq.pop_front();
                    chk("wr_we", int'(bus.tbl_we_o), 1);
                    chk("wr_addr", int'(bus.tbl_addr_o), e.idx);
                    chk("wr_wdata", int'(bus.tbl_wdata_o), e.val);
                end else begin
                    chk("idle_we", int'(bus.tbl_we_o), 0);
                    chk("idle_wdata", int'(bus.tbl_wdata_o), 0);
                    if (sbq.size() > 0 && cyc == sbq[0].w - 1)
                        chk("rd_addr", int'(bus.tbl_addr_o), sbq[0].idx);
                end
            end
        end
    end

    task automatic do_reset();
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        vld_pct = 100;
        repeat (60) @(negedge clk);
        vld_pct = 30;
        repeat (300) @(negedge clk);
        vld_pct = 100;
        repeat (200) @(negedge clk);
        @(negedge clk);
        do_reset();
        vld_pct = 100;
        if (SWEEP) begin
            for (int i = 0; i < 40 && cyc != 10; i++) @(negedge clk);
        end else begin
            for (int i = 0; i < 40 && !bus.tbl_we_o; i++) @(negedge clk);
        end
        do_reset();
        vld_pct = 60;
        repeat (400) @(negedge clk);
        vld_pct = 0;
        repeat (40) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
